// File: rtl/key_pkg.sv
// Shared types and constants for the push-button scanner.
// Debounce defaults, key count and the per-key state encoding.
package key_pkg;

  localparam int DB_CYCLES_DEFAULT = 1_000_000;
  localparam int NKEYS = 4;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } key_state_t;

  function automatic logic [1:0] low_idx(
    input logic [NKEYS-1:0] v
  );
    logic [1:0] r;
    r = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (v[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer, stability counter and edge detect.
// Pulses and next level are decoded from registers only.
module key_debounce
  import key_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rest,
  input  logic keyn,
  output logic level_nxt,
  output logic down,
  output logic up
);

  localparam int CW = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic          stable_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          fire;
  key_state_t    st;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
    end else begin
      s1     <= keyn;
      s2     <= s1;
      stable <= stable_n;
      cnt    <= cnt_n;
    end
  end

  always_comb begin
    cnt_n    = '0;
    stable_n = stable;
    fire     = 1'b0;
    st       = RELEASED;
    unique case (1'b1)
      ( stable &&  s2): st = RELEASED;
      ( stable && !s2): st = PRESS_DB;
      (!stable && !s2): st = HELD;
      (!stable &&  s2): st = RELEASE_DB;
      default:          st = RELEASED;
    endcase
    unique case (st)
      RELEASED, HELD: cnt_n = '0;
      PRESS_DB, RELEASE_DB: begin
        if (cnt == CMAX) begin
          fire     = 1'b1;
          stable_n = s2;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: cnt_n = '0;
    endcase
  end

  // stable is active-low: a fire while released is a press
  assign level_nxt = ~stable_n;
  assign down      = fire & stable;
  assign up        = fire & ~stable;

endmodule

// File: rtl/key_scan.sv
// Four-key debounced scanner with registered level, edge pulses
// and lowest-index key code.
module key_scan
  import key_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int NKEYS     = key_pkg::NKEYS
) (
  input  logic             clk,
  input  logic             rest,
  input  logic [NKEYS-1:0] keyn,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_down,
  output logic [NKEYS-1:0] key_up,
  output logic             key_valid,
  output logic [1:0]       key_code
);

  logic [NKEYS-1:0] lvl_n;
  logic [NKEYS-1:0] dn;
  logic [NKEYS-1:0] upp;

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk      (clk),
      .rest     (rest),
      .keyn     (keyn[i]),
      .level_nxt(lvl_n[i]),
      .down     (dn[i]),
      .up       (upp[i])
    );
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      key_level <= '0;
      key_down  <= '0;
      key_up    <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      key_level <= lvl_n;
      key_down  <= dn;
      key_up    <= upp;
      key_valid <= |dn;
      if (|dn) key_code <= low_idx(dn);
    end
  end

endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 Parameter: DB_CYCLES, 1_000_000, number of consecutive stable clocks required to accept a key level change (20 ms at 50 MHz); legal range 2 to 2^24-1.
REQ-002 Parameter: NKEYS, 4, number of push-button inputs; fixed at 4 for this revision.
REQ-003 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port: rest  input  1  reset, asynchronous, active-low.
REQ-005 Port: keyn  input  4  raw push-button levels, active-low (0 = pressed), asynchronous to clk.
REQ-006 Port: key_level  output  4  debounced level per key, active-high (1 = held).
REQ-007 Port: key_down  output  4  one-clock pulse per key on the accepted press.
REQ-008 Port: key_up  output  4  one-clock pulse per key on the accepted release.
REQ-009 Port: key_valid  output  1  one-clock pulse whenever any bit of key_down is 1.
REQ-010 Port: key_code  output  2  index of the lowest-numbered key pulsing key_down; meaningful only while key_valid=1, and holds its last value otherwise.

Function
REQ-011 Each keyn bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Per key: a stable register and a counter sized $clog2(DB_CYCLES)+1 bits.
REQ-013 Counter rule: synced==stable -> counter cleared; synced!=stable and counter<DB_CYCLES-1 -> increment; synced!=stable and counter==DB_CYCLES-1 -> stable<=synced, counter<=0, emit edge pulse.
REQ-014 A raw level held steady SHALL produce its pulse exactly DB_CYCLES+2 clocks after the raw edge (2 synchronizer + DB_CYCLES debounce).
REQ-015 Any glitch shorter than DB_CYCLES synchronized clocks SHALL restart the count and produce no pulse and no key_level change.
REQ-016 key_level = ~stable; key_down asserts on a 1->0 stable change; key_up asserts on a 0->1 stable change; each pulse is exactly one clock wide.
REQ-017 Per-key state machine, encoded from the stable bit and the counter state: RELEASED, PRESS_DB (counting toward pressed), HELD, RELEASE_DB (counting toward released). Transitions are as defined in REQ-013.
REQ-018 Simultaneous presses in one cycle: all affected key_down bits assert; key_code = lowest index; key_valid asserts once.
REQ-019 key_down and key_up on different keys in the same cycle are independent and both SHALL be reported.
REQ-020 Outputs SHALL be registered, with no combinational path from keyn to any output.

Reset
REQ-021 While rest=0: synchronizer flops=1, stable=1 (released), counters=0, key_level=0, key_down=0, key_up=0, key_valid=0, key_code=0.
REQ-022 If a key is low when rest deasserts, it SHALL be reported as a normal press DB_CYCLES+2 clocks after rest rises.
REQ-023 Reset asserted mid-debounce SHALL discard the partial count; no pulse is emitted for that edge.

Structure
REQ-024 Shared package key_pkg: DB_CYCLES_DEFAULT, NKEYS, state enum {RELEASED, PRESS_DB, HELD, RELEASE_DB}.
REQ-025 Sub-module key_debounce: one key's synchronizer, counter and edge-pulse logic, instantiated NKEYS times; priority encode and output registers live in key_scan.

Verification (DB_CYCLES=16)
REQ-026 Scenario: keyn[0] 1->0 held -> key_down=0001, key_valid=1, key_code=0 at exactly clock 18 after the edge; key_level[0]=1 thereafter.
REQ-027 Scenario: keyn[2] low 10 clocks then high -> no key_down, key_level stays 0000.
REQ-028 Scenario: keyn[3] and keyn[1] fall in the same cycle -> one cycle with key_down=1010, key_code=1, key_valid=1.
REQ-029 Scenario: key 0 held, then released -> key_up=0001 for exactly one clock, 18 clocks after the rising edge; key_level[0]=0.
REQ-030 Scenario: rest pulsed low at clock 10 of key 1's debounce -> all outputs 0 during reset; after rest rises with keyn[1] still low, key_down=0010 18 clocks later.
REQ-031 Scenario: keyn[0] chatters (toggling every 5 clocks for 40 clocks) then settles low -> exactly one key_down pulse, 18 clocks after the last toggle.
